// File: rtl/bcd_scan_mux_if.sv
// Scanner bus: captured BCD value in, scanned digit and selects out.
// master drives load/value/blank_lz; slave returns digit/blank/dig_sel/err.
interface bcd_scan_mux_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic                  blank_lz;
  logic [3:0]            digit;
  logic                  blank;
  logic [DIGITS-1:0]     dig_sel;
  logic                  err;

  modport master (
    output load, value, blank_lz,
    input  digit, blank, dig_sel, err
  );

  modport slave (
    input  load, value, blank_lz,
    output digit, blank, dig_sel, err
  );
endinterface

// File: rtl/bcd_scan_mux.sv
// Multiplexed BCD display scanner feeding a sevenseg decoder.
// Ports: clk, rst_n (async low), bus (slave: load/value/blank_lz in; digit/blank/dig_sel/err out).
module bcd_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  bcd_scan_mux_if.slave bus
);
  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);

  typedef enum logic {GAP, SCAN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [IW-1:0]       idx_q;
  logic [4*DIGITS-1:0] shadow_q;
  logic                tick;
  logic [3:0]          digit_q, digit_d;
  logic                blank_q, blank_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                err_q;
  logic                bad;
  logic [3:0]          nib;
  logic                lead;
  logic                lz_hit;
  logic [3:0]          show_digit;
  logic                show_blank;

  assign tick = (cnt_q == CW'(PRESCALE - 1));

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.value[4*i +: 4] > 4'd9) bad = 1'b1;
    end
  end

  // lead stays set only if every nibble from the top down to idx is zero;
  // invalid nibbles are nonzero, so they end a leading-zero run.
  always_comb begin
    nib  = 4'd0;
    lead = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx_q) nib = shadow_q[4*i +: 4];
      if (i >= int'(idx_q) && shadow_q[4*i +: 4] != 4'd0)
        lead = 1'b0;
    end
  end

  assign lz_hit = bus.blank_lz && (idx_q != '0) && lead;

  // The decoder has no default case: never pass it a nibble above 9.
  always_comb begin
    show_digit = nib;
    show_blank = 1'b0;
    unique case (1'b1)
      (nib > 4'd9): begin
        show_digit = 4'd0;
        show_blank = 1'b1;
      end
      lz_hit: begin
        show_digit = 4'd0;
        show_blank = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    digit_d = digit_q;
    blank_d = blank_q;
    unique case (state_q)
      GAP: begin
        state_d = SCAN;
        sel_d   = ~(DIGITS'(1) << idx_q);
        digit_d = show_digit;
        blank_d = show_blank;
      end
      SCAN: begin
        digit_d = show_digit;
        blank_d = show_blank;
        if (tick) begin
          state_d = GAP;
          sel_d   = '1;
        end
      end
      default: state_d = GAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      state_q  <= GAP;
      shadow_q <= '0;
      err_q    <= 1'b0;
      digit_q  <= 4'd0;
      blank_q  <= 1'b0;
      sel_q    <= '1;
    end else begin
      cnt_q   <= tick ? '0 : cnt_q + CW'(1);
      if (tick)
        idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      state_q <= state_d;
      digit_q <= digit_d;
      blank_q <= blank_d;
      sel_q   <= sel_d;
      if (bus.load) begin
        shadow_q <= bus.value;
        err_q    <= bad;
      end
    end
  end

  assign bus.digit   = digit_q;
  assign bus.blank   = blank_q;
  assign bus.dig_sel = sel_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_bcd_scan_mux.sv
// Self-checking bench for bcd_scan_mux (DIGITS=4, PRESCALE=4).
// Compares each cycle against a slot-arithmetic reference model.
module tb_bcd_scan_mux;
  localparam int D = 4;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  bcd_scan_mux_if #(.DIGITS(D)) bus();

  bcd_scan_mux #(.DIGITS(D), .PRESCALE(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: k = edges since reset release.
  int         k = 0;
  logic [15:0] m_shadow = '0;
  logic       m_err = 1'b0;
  logic [3:0] e_digit = 4'd0;
  logic       e_blank = 1'b0;
  logic [3:0] e_sel = 4'hF;

  function automatic logic [4:0] show(input logic [15:0] s,
                                      input int i, input logic lz);
    int n;
    bit allz;
    n = int'((s >> (4*i)) & 16'hF);
    if (n > 9) return {4'd0, 1'b1};
    allz = 1;
    for (int j = i; j < D; j++)
      if (((s >> (4*j)) & 16'hF) != 0) allz = 0;
    if (lz && i > 0 && allz) return {4'd0, 1'b1};
    return {4'(n), 1'b0};
  endfunction

  function automatic logic any_bad(input logic [15:0] v);
    for (int j = 0; j < D; j++)
      if (((v >> (4*j)) & 16'hF) > 9) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0; m_shadow = '0; m_err = 1'b0;
      e_digit = 4'd0; e_blank = 1'b0; e_sel = 4'hF;
    end else begin
      k = k + 1;
      {e_digit, e_blank} = show(m_shadow, ((k - 1) / P) % D, bus.blank_lz);
      e_sel = (k % P == 0) ? 4'hF : ~(4'b0001 << ((k / P) % D));
      if (bus.load) begin
        m_shadow = bus.value;
        m_err = any_bad(bus.value);
      end
    end
  end

  task automatic test_reset();
    logic [3:0] slot_sel [12];
    slot_sel = '{4'b1110, 4'b1110, 4'b1110, 4'b1111,
                 4'b1101, 4'b1101, 4'b1101, 4'b1111,
                 4'b1011, 4'b1011, 4'b1011, 4'b1111};
    bus.load = 1'b0; bus.value = '0; bus.blank_lz = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.dig_sel, bus.digit, bus.blank, bus.err} !== {4'hF, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got sel=%b d=%0d b=%b e=%b want 1111/0/0/0",
               bus.dig_sel, bus.digit, bus.blank, bus.err);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.dig_sel !== slot_sel[c] || bus.digit !== 4'd0) begin
        errors++;
        $display("FAIL first_slots c=%0d got sel=%b d=%0d want sel=%b d=0",
                 c, bus.dig_sel, bus.digit, slot_sel[c]);
      end
    end
  endtask

  task automatic test_scan_order();
    @(negedge clk) begin bus.load = 1'b1; bus.value = 16'h1234; end
    @(negedge clk) bus.load = 1'b0;
    for (int c = 0; c < 34; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.dig_sel, bus.digit, bus.blank, bus.err} !==
          {e_sel, e_digit, e_blank, m_err} || bus.err !== 1'b0) begin
        errors++;
        $display("FAIL scan_order k=%0d got %b/%0d/%b/%b want %b/%0d/%b/0",
                 k, bus.dig_sel, bus.digit, bus.blank, bus.err,
                 e_sel, e_digit, e_blank);
      end
      if (e_sel == 4'b0111 && k % P == 3) begin
        checks++;
        if (bus.digit !== 4'd1) begin
          errors++;
          $display("FAIL scan_msd got %0d want 1", bus.digit);
        end
      end
    end
  endtask

  task automatic test_lz();
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk) begin
        bus.load = 1'b1; bus.value = 16'h0050; bus.blank_lz = (pass == 0);
      end
      @(negedge clk) bus.load = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        checks++;
        if ({bus.dig_sel, bus.digit, bus.blank, bus.err} !==
            {e_sel, e_digit, e_blank, m_err}) begin
          errors++;
          $display("FAIL lz pass=%0d k=%0d got %b/%0d/%b/%b want %b/%0d/%b/%b",
                   pass, k, bus.dig_sel, bus.digit, bus.blank, bus.err,
                   e_sel, e_digit, e_blank, m_err);
        end
        if (e_sel != 4'hF && k % P == 2) begin
          checks++;
          if (bus.blank !== (pass == 0 && e_sel[3:2] != 2'b11)) begin
            errors++;
            $display("FAIL lz_blank pass=%0d sel=%b got %b", pass, e_sel, bus.blank);
          end
        end
      end
    end
    bus.blank_lz = 1'b0;
  endtask

  task automatic test_invalid();
    @(negedge clk) begin bus.load = 1'b1; bus.value = 16'h12A4; end
    @(posedge clk); #1;
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL err_set got %b want 1", bus.err);
    end
    @(negedge clk) bus.load = 1'b0;
    for (int c = 0; c < 17; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.dig_sel, bus.digit, bus.blank, bus.err} !==
          {e_sel, e_digit, e_blank, m_err}) begin
        errors++;
        $display("FAIL invalid k=%0d got %b/%0d/%b/%b want %b/%0d/%b/%b",
                 k, bus.dig_sel, bus.digit, bus.blank, bus.err,
                 e_sel, e_digit, e_blank, m_err);
      end
      if (e_sel == 4'b1101 && k % P == 3) begin
        checks++;
        if (bus.digit !== 4'd0 || bus.blank !== 1'b1) begin
          errors++;
          $display("FAIL invalid_slot got d=%0d b=%b want 0/1", bus.digit, bus.blank);
        end
      end
    end
    @(negedge clk) begin bus.load = 1'b1; bus.value = 16'h0009; end
    @(posedge clk); #1;
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b want 0", bus.err);
    end
    @(negedge clk) bus.load = 1'b0;
  endtask

  task automatic test_mid_load();
    logic [4:0] want;
    int         n;
    @(negedge clk) begin bus.load = 1'b1; bus.value = 16'h1234; end
    @(negedge clk) bus.load = 1'b0;
    n = 0;
    while (!(k % P == 1 && (k / P) % D == 0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL mid_wait timeout");
    end
    checks++;
    if (bus.digit !== 4'd4 || bus.dig_sel !== 4'b1110) begin
      errors++;
      $display("FAIL mid_pre got d=%0d sel=%b want 4/1110", bus.digit, bus.dig_sel);
    end
    @(negedge clk) begin bus.load = 1'b1; bus.value = 16'h1238; end
    @(negedge clk) bus.load = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.digit !== 4'd8 || bus.dig_sel !== 4'b1110) begin
      errors++;
      $display("FAIL mid_load got d=%0d sel=%b want 8/1110", bus.digit, bus.dig_sel);
    end
    n = 0;
    while (k % P != P - 1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(negedge clk) begin bus.load = 1'b1; bus.value = 16'h5678; end
    @(negedge clk) bus.load = 1'b0;
    @(posedge clk); #1;
    want = show(16'h5678, (k / P) % D, 1'b0);
    checks++;
    if ({bus.digit, bus.blank} !== want || bus.dig_sel !== e_sel) begin
      errors++;
      $display("FAIL tick_load got d=%0d b=%b sel=%b want d=%0d b=%b sel=%b",
               bus.digit, bus.blank, bus.dig_sel, want[4:1], want[0], e_sel);
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk) begin
        v = '0;
        for (int j = 0; j < D; j++)
          if ($urandom_range(0, 2) != 0)
            v[4*j +: 4] = ($urandom_range(0, 7) == 0) ?
                          4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        bus.load = ($urandom_range(0, 5) == 0);
        bus.value = v;
        bus.blank_lz = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      checks++;
      if ({bus.dig_sel, bus.digit, bus.blank, bus.err} !==
          {e_sel, e_digit, e_blank, m_err}) begin
        errors++;
        $display("FAIL random k=%0d got %b/%0d/%b/%b want %b/%0d/%b/%b",
                 k, bus.dig_sel, bus.digit, bus.blank, bus.err,
                 e_sel, e_digit, e_blank, m_err);
      end
    end
    @(negedge clk) begin bus.load = 1'b0; bus.blank_lz = 1'b0; end
  endtask

  task automatic test_async_reset();
    int n;
    @(negedge clk) begin bus.load = 1'b1; bus.value = 16'h12A4; end
    @(negedge clk) bus.load = 1'b0;
    n = 0;
    while (!(k % P == 2 && (k / P) % D == 2) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL reset_wait timeout");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.dig_sel, bus.digit, bus.blank, bus.err} !== {4'hF, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got %b/%0d/%b/%b want 1111/0/0/0",
               bus.dig_sel, bus.digit, bus.blank, bus.err);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus.dig_sel, bus.digit, bus.blank, bus.err} !==
          {e_sel, e_digit, e_blank, m_err}) begin
        errors++;
        $display("FAIL restart k=%0d got %b/%0d/%b/%b want %b/%0d/%b/%b",
                 k, bus.dig_sel, bus.digit, bus.blank, bus.err,
                 e_sel, e_digit, e_blank, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_lz();
    test_invalid();
    test_mid_load();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
